// File: rtl/aes_text_out_serializer.sv
// aes_text_out_serializer
//   Drain side of the AES cipher core result path. Each `done` pulse captures
//   the DATA_W-bit `text_out` block into a 2-entry block FIFO. Buffered blocks
//   are streamed out as OUT_W-bit words, most-significant word first, over a
//   valid/ready handshake.
//
//   Optional build macro: AES_SER_PARITY_EN adds m_parity (per-byte XOR of
//   m_data, registered alongside it).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   done      one-cycle pulse from the core; text_out valid in that cycle
//   text_out  ciphertext block
//   m_valid   output word valid
//   m_ready   consumer accepts the word when m_valid && m_ready
//   m_data    current output word
//   m_last    high with the final word of a block
//   busy      high while any block is buffered or streaming
//   overrun   one-cycle pulse when a done is dropped because the buffer is full
//   m_parity  (AES_SER_PARITY_EN only) even parity per byte of m_data
module aes_text_out_serializer #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] text_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overrun
`ifdef AES_SER_PARITY_EN
  ,
  output logic [OUT_W/8-1:0] m_parity
`endif
);

  localparam int NWORDS = DATA_W / OUT_W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   entries   [2];
  logic [DATA_W-1:0]   entries_n [2];
  logic                wptr, wptr_n, rptr, rptr_n;
  logic [1:0]          count, count_n;
  logic [IW-1:0]       idx, idx_n;
  logic [OUT_W-1:0]    m_data_n;
  logic                m_last_n, busy_n, overrun_n;
  logic                hs, pop, capture;
  logic [DATA_W-1:0]   sel;

  assign m_valid = (state == STREAM);

  // Outputs are computed from the next-state view of the buffer so that a
  // capture into an empty buffer presents word 0 on the following cycle.
  always_comb begin
    hs        = m_valid && m_ready;
    pop       = hs && (idx == IW'(NWORDS - 1));
    // A pop of the last word frees a slot in the same cycle, so a full buffer
    // can still accept the block.
    capture   = done && ((count != 2'd2) || pop);
    overrun_n = done && !capture;

    entries_n = entries;
    wptr_n    = wptr;
    rptr_n    = rptr;
    count_n   = count;
    idx_n     = idx;

    if (capture) begin
      entries_n[wptr] = text_out;
      wptr_n          = ~wptr;
    end
    if (pop) begin
      rptr_n = ~rptr;
    end
    if (capture && !pop) begin
      count_n = count + 2'd1;
    end else if (!capture && pop) begin
      count_n = count - 2'd1;
    end
    if (hs) begin
      idx_n = pop ? '0 : idx + IW'(1);
    end

    state_n  = (count_n != 2'd0) ? STREAM : IDLE;
    busy_n   = (count_n != 2'd0);
    sel      = entries_n[rptr_n] << (int'(idx_n) * OUT_W);
    m_data_n = (state_n == STREAM) ? sel[DATA_W-1 -: OUT_W] : '0;
    m_last_n = (state_n == STREAM) && (idx_n == IW'(NWORDS - 1));
  end

`ifdef AES_SER_PARITY_EN
  logic [OUT_W/8-1:0] parity_n;

  always_comb begin
    parity_n = '0;
    for (int unsigned k = 0; k < OUT_W / 8; k++) begin
      parity_n[k] = ^m_data_n[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_parity <= '0;
    end else begin
      m_parity <= parity_n;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      entries[0] <= '0;
      entries[1] <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      count      <= 2'd0;
      idx        <= '0;
      m_data     <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      entries[0] <= entries_n[0];
      entries[1] <= entries_n[1];
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      count      <= count_n;
      idx        <= idx_n;
      m_data     <= m_data_n;
      m_last     <= m_last_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
    end
  end

endmodule
